axi_lite_master: RTL and testbench

// - Single-shot AXI4-Lite master: a start pulse writes tgt_data to tgt_addr, then reads the same address back.
// - Flags completion, and flags an error on a non-OKAY response or a readback mismatch.
// - Sits between a local control/test sequencer and one AXI4-Lite slave; one transaction in flight at a time.

---
 rtl/axi_lite_master_pkg.sv | 19 +
 rtl/axi_lite_master.sv | 139 +++++++++++++
 tb/tb_axi_lite_master.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_pkg.sv
// Shared definitions for the single-shot AXI4-Lite master.
// - AXI response codes
// - FSM state encoding for the write-then-readback sequence
package axi_lite_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_READ,
    ST_RRESP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-shot AXI4-Lite master.
// A rising edge on INT_AXI_TXN (sampled in IDLE) latches tgt_addr/tgt_data,
// writes the data to the address, then reads the address back and compares
// the result with the written data. Completion is flagged by a one-cycle
// txn_done pulse; txn_error pulses with it if any response was non-OKAY or
// the readback data differed.
// Ports:
//   aclk, areset              clock, async active-high reset
//   INT_AXI_TXN               start request (rising edge)
//   tgt_addr, tgt_data        target address / write+compare data
//   txn_done, txn_error       completion / error pulses
//   aw*, w*, b*, ar*, r*      AXI4-Lite master channels
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      INT_AXI_TXN,
  input  logic [ADDR_WIDTH-1:0]     tgt_addr,
  input  logic [DATA_WIDTH-1:0]     tgt_data,
  output logic                      txn_done,
  output logic                      txn_error,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);

  state_t state;
  logic   start_d;   // previous-cycle INT_AXI_TXN for edge detection
  logic   aw_done;   // AW handshake already taken in this WRITE phase
  logic   w_done;    // W handshake already taken in this WRITE phase
  logic   err;       // sticky error record for the current sequence
  logic   aw_hs;
  logic   w_hs;

  assign wstrb = '1;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= ST_IDLE;
      start_d   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      err       <= 1'b0;
      txn_done  <= 1'b0;
      txn_error <= 1'b0;
      awaddr    <= '0;
      araddr    <= '0;
      wdata     <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
    end else begin
      start_d   <= INT_AXI_TXN;
      txn_done  <= 1'b0;
      txn_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (INT_AXI_TXN && !start_d) begin
            awaddr  <= tgt_addr;
            araddr  <= tgt_addr;
            wdata   <= tgt_data;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          // A handshake in this very cycle counts as done, so AW and W may
          // finish together or in either order without an extra wait cycle.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready <= 1'b1;
            state  <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (bvalid && bready) begin
            if (bresp != RESP_OKAY) err <= 1'b1;
            bready  <= 1'b0;
            arvalid <= 1'b1;
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_RRESP;
          end
        end
        ST_RRESP: begin
          if (rvalid && rready) begin
            rready    <= 1'b0;
            txn_done  <= 1'b1;
            txn_error <= err || (rresp != RESP_OKAY) || (rdata != wdata);
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          err   <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed testbench for axi_lite_master with a configurable AXI4-Lite slave.
module tb_axi_lite_master;
  import axi_lite_master_pkg::*;

  logic        aclk;
  logic        areset;
  logic        INT_AXI_TXN;
  logic [3:0]  tgt_addr;
  logic [31:0] tgt_data;
  logic        txn_done;
  logic        txn_error;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  axi_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset), .INT_AXI_TXN(INT_AXI_TXN),
    .tgt_addr(tgt_addr), .tgt_data(tgt_data),
    .txn_done(txn_done), .txn_error(txn_error),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // slave configuration (written by the main sequence only)
  int          aw_delay  = 0;
  int          w_delay   = 0;
  logic        b_early   = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  logic [1:0]  rresp_cfg = 2'b00;
  logic        clr_req   = 1'b0;

  // slave observations (written by the slave process only)
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  int          done_cnt, err_cnt, stray_err, bready_early, drop_err, done_cyc;
  logic [3:0]  cap_awaddr, cap_araddr, cap_wstrb;
  logic [31:0] cap_wdata;

  int asserts = 0;
  int failures = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: acts on falling edges; a *_fire flag marks a handshake that
  // completes on the following rising edge and is accounted one negedge later.
  initial begin
    logic aw_fire, w_fire, b_fire, ar_fire, r_fire, b_given, r_given, prev_awv, prev_wv;
    int   aw_wait, w_wait;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
    rvalid = 0; rdata = '0; rresp = 0;
    aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
    b_given = 0; r_given = 0; prev_awv = 0; prev_wv = 0; aw_wait = 0; w_wait = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    done_cnt = 0; err_cnt = 0; stray_err = 0; bready_early = 0; drop_err = 0; done_cyc = 0;
    cap_awaddr = 0; cap_araddr = 0; cap_wstrb = 0; cap_wdata = 0;
    forever begin
      @(negedge aclk);
      if (clr_req) begin
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        done_cnt = 0; err_cnt = 0; stray_err = 0; bready_early = 0; drop_err = 0;
        b_given = 0; r_given = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
        ar_fire = 0; r_fire = 0;
        cap_awaddr = 0; cap_araddr = 0; cap_wstrb = 0; cap_wdata = 0;
      end
      if (aw_fire) aw_hs++;
      if (w_fire) w_hs++;
      if (b_fire) begin b_hs++; bvalid = 0; end
      if (ar_fire) ar_hs++;
      if (r_fire) begin r_hs++; rvalid = 0; end
      if (!areset && prev_awv && !awvalid && !aw_fire) drop_err++;
      if (!areset && prev_wv && !wvalid && !w_fire) drop_err++;
      if (bready && (aw_hs == 0 || w_hs == 0)) bready_early++;
      if (txn_done) begin done_cnt++; done_cyc = cyc; end
      if (txn_error) err_cnt++;
      if (txn_error && !txn_done) stray_err++;
      if (awvalid && !areset) begin awready = (aw_wait >= aw_delay); aw_wait++; end
      else begin awready = 0; aw_wait = 0; end
      if (wvalid && !areset) begin wready = (w_wait >= w_delay); w_wait++; end
      else begin wready = 0; w_wait = 0; end
      arready = arvalid && !areset;
      if (areset) begin
        bvalid = 0; rvalid = 0;
      end else begin
        if (!bvalid && !b_given &&
            (b_early ? (awvalid || aw_hs > 0) : (aw_hs > 0 && w_hs > 0))) begin
          bvalid = 1; bresp = bresp_cfg; b_given = 1;
        end
        if (!rvalid && !r_given && ar_hs > 0) begin
          rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; r_given = 1;
        end
      end
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      b_fire  = bvalid && bready;
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      if (aw_fire) cap_awaddr = awaddr;
      if (w_fire) begin cap_wdata = wdata; cap_wstrb = wstrb; end
      if (ar_fire) cap_araddr = araddr;
      prev_awv = awvalid;
      prev_wv  = wvalid;
    end
  end

  task automatic clear_slave();
    clr_req = 1'b1;
    repeat (2) @(negedge aclk);
    clr_req = 1'b0;
  endtask

  task automatic start_pulse(input logic [3:0] a, input logic [31:0] d, input int hold);
    @(negedge aclk);
    tgt_addr = a;
    tgt_data = d;
    INT_AXI_TXN = 1'b1;
    start_cyc = cyc;
    repeat (hold) @(negedge aclk);
    INT_AXI_TXN = 1'b0;
  endtask

  task automatic run_txn(input logic [3:0] a, input logic [31:0] d, input int hold);
    int n;
    clear_slave();
    start_pulse(a, d, hold);
    n = 0;
    while (done_cnt == 0 && n < 60) begin
      @(negedge aclk);
      n++;
    end
    if (done_cnt == 0) check("txn_done_timeout", 64'(0), 64'(1));
    repeat (4) @(negedge aclk);
  endtask

  initial begin
    areset = 1'b1; INT_AXI_TXN = 1'b0; tgt_addr = '0; tgt_data = '0;
    repeat (3) @(negedge aclk);
    check("rst_awvalid", 64'(awvalid), 64'(0));
    check("rst_wvalid", 64'(wvalid), 64'(0));
    check("rst_bready", 64'(bready), 64'(0));
    check("rst_arvalid", 64'(arvalid), 64'(0));
    check("rst_rready", 64'(rready), 64'(0));
    check("rst_done", 64'(txn_done), 64'(0));
    check("rst_awaddr", 64'(awaddr), 64'(0));
    check("rst_wdata", 64'(wdata), 64'(0));
    check("rst_wstrb", 64'(wstrb), 64'hF);
    areset = 1'b0;
    repeat (2) @(negedge aclk);

    // 1: AW/W one cycle late, clean response
    aw_delay = 1; w_delay = 1; b_early = 0;
    bresp_cfg = RESP_OKAY; rdata_cfg = 32'hFFFF_FFFF; rresp_cfg = RESP_OKAY;
    run_txn(4'h5, 32'hFFFF_FFFF, 1);
    check("t1_awaddr", 64'(cap_awaddr), 64'h5);
    check("t1_wdata", 64'(cap_wdata), 64'hFFFF_FFFF);
    check("t1_wstrb", 64'(cap_wstrb), 64'hF);
    check("t1_araddr", 64'(cap_araddr), 64'h5);
    check("t1_done", 64'(done_cnt), 64'(1));
    check("t1_error", 64'(err_cnt), 64'(0));
    check("t1_aw_hs", 64'(aw_hs), 64'(1));
    check("t1_w_hs", 64'(w_hs), 64'(1));
    check("t1_b_hs", 64'(b_hs), 64'(1));
    check("t1_r_hs", 64'(r_hs), 64'(1));
    check("t1_drop", 64'(drop_err), 64'(0));

    // 2: zero-wait slave, start-to-done latency
    aw_delay = 0; w_delay = 0; rdata_cfg = 32'h1234_5678;
    run_txn(4'hA, 32'h1234_5678, 1);
    check("t2_latency", 64'(done_cyc - start_cyc), 64'(5));
    check("t2_error", 64'(err_cnt), 64'(0));
    check("t2_araddr", 64'(cap_araddr), 64'hA);

    // 3: SLVERR write response, read still issued
    aw_delay = 1; w_delay = 1; bresp_cfg = RESP_SLVERR; rdata_cfg = 32'hFFFF_FFFF;
    run_txn(4'h5, 32'hFFFF_FFFF, 1);
    check("t3_ar_hs", 64'(ar_hs), 64'(1));
    check("t3_done", 64'(done_cnt), 64'(1));
    check("t3_error", 64'(err_cnt), 64'(1));
    check("t3_stray", 64'(stray_err), 64'(0));
    bresp_cfg = RESP_OKAY;

    // 4: readback mismatch
    rdata_cfg = 32'h0000_FFFF;
    run_txn(4'h5, 32'hFFFF_FFFF, 1);
    check("t4_done", 64'(done_cnt), 64'(1));
    check("t4_error", 64'(err_cnt), 64'(1));

    // 5: DECERR on read response with matching data
    rdata_cfg = 32'hA5A5_5A5A; rresp_cfg = RESP_DECERR;
    run_txn(4'h3, 32'hA5A5_5A5A, 1);
    check("t5_error", 64'(err_cnt), 64'(1));
    rresp_cfg = RESP_OKAY;

    // 6: awready 3 cycles before wready, B raised early; error record cleared
    aw_delay = 0; w_delay = 3; b_early = 1; rdata_cfg = 32'hCAFE_0001;
    run_txn(4'hC, 32'hCAFE_0001, 1);
    check("t6_bready_early", 64'(bready_early), 64'(0));
    check("t6_b_hs", 64'(b_hs), 64'(1));
    check("t6_aw_hs", 64'(aw_hs), 64'(1));
    check("t6_w_hs", 64'(w_hs), 64'(1));
    check("t6_drop", 64'(drop_err), 64'(0));
    check("t6_done", 64'(done_cnt), 64'(1));
    check("t6_error", 64'(err_cnt), 64'(0));
    b_early = 0;

    // 7: start held high for 20 cycles -> one transaction
    aw_delay = 0; w_delay = 0; rdata_cfg = 32'h0BAD_F00D;
    run_txn(4'h7, 32'h0BAD_F00D, 20);
    repeat (5) @(negedge aclk);
    check("t7_done", 64'(done_cnt), 64'(1));
    check("t7_aw_hs", 64'(aw_hs), 64'(1));
    check("t7_error", 64'(err_cnt), 64'(0));

    // 8: reset mid-WRITE
    aw_delay = 50; w_delay = 50;
    clear_slave();
    start_pulse(4'h9, 32'h5555_AAAA, 1);
    repeat (2) @(negedge aclk);
    check("t8_pre_awvalid", 64'(awvalid), 64'(1));
    areset = 1'b1;
    #1;
    check("t8_awvalid", 64'(awvalid), 64'(0));
    check("t8_wvalid", 64'(wvalid), 64'(0));
    check("t8_state", 64'(dut.state), 64'(ST_IDLE));
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    repeat (10) @(negedge aclk);
    check("t8_done", 64'(done_cnt), 64'(0));
    check("t8_idle_awvalid", 64'(awvalid), 64'(0));

    // 9: recovery after reset
    aw_delay = 0; w_delay = 0; rdata_cfg = 32'h0000_0001;
    run_txn(4'h1, 32'h0000_0001, 1);
    check("t9_done", 64'(done_cnt), 64'(1));
    check("t9_error", 64'(err_cnt), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
